// File: rtl/user_logic_record_pkg.sv
// Shared definitions for the trigger-gated record packager: FSM encoding,
// user-register indices and control-word bit positions.
package user_logic_record_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_RECORD = 3'd3,
    ST_DONE   = 3'd4
  } rec_state_e;

  localparam int REG_W     = 16;
  localparam int REG_CTRL  = 0;
  localparam int REG_DELAY = 1;
  localparam int REG_LEN   = 2;
  localparam int REG_DECIM = 3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_SEL_LSB = 2;
  localparam int CTRL_SEL_MSB = 3;
  localparam int CTRL_CONT    = 4;
  localparam int CTRL_CLR     = 5;

  // Status counters stick at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/user_logic_record_gate_if.sv
// Sample/trigger/register bundle between the acquisition front end (master)
// and the record gate (slave).
interface user_logic_record_gate_if #(
  parameter int NofBits             = 16,
  parameter int NofChannels         = 2,
  parameter int NofUserRegistersOut = 4
);
  logic [NofBits*NofChannels-1:0]    x_i;
  logic [NofBits*NofChannels-1:0]    xz_i;
  logic                              data_valid_i;
  logic [3:0]                        trigger_vector_i;
  logic [16*8-1:0]                   user_register_i;
  logic [NofBits*NofChannels-1:0]    y_o;
  logic [NofBits*NofChannels-1:0]    yz_o;
  logic                              data_valid_o;
  logic [3:0]                        trigger_vector_o;
  logic [16*NofUserRegistersOut-1:0] user_register_o;

  modport master (
    output x_i, xz_i, data_valid_i, trigger_vector_i, user_register_i,
    input  y_o, yz_o, data_valid_o, trigger_vector_o, user_register_o
  );

  modport slave (
    input  x_i, xz_i, data_valid_i, trigger_vector_i, user_register_i,
    output y_o, yz_o, data_valid_o, trigger_vector_o, user_register_o
  );
endinterface

// File: rtl/user_logic_record_ctrl.sv
// Record FSM with edge detect, delay/length counters and status counters.
// Optional decimation inside a record is built with USER_LOGIC_RECORD_DECIM_EN.
module user_logic_record_ctrl
  import user_logic_record_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        data_valid_i,
  input  logic [3:0]  trigger_vector_i,
  input  logic [15:0] ctrl_i,
  input  logic [15:0] delay_i,
  input  logic [15:0] len_i,
  input  logic [3:0]  decim_i,
  output logic        pass_o,
  output rec_state_e  state_o,
  output logic [15:0] rec_cnt_o,
  output logic [15:0] miss_cnt_o
);

  rec_state_e  state, state_next;
  logic [3:0]  trig_prev;
  logic [15:0] dly_q, len_q, dly_cnt, pass_cnt;
  logic [15:0] len_eff, cnt_eff;
  logic [1:0]  sel;
  logic        enable, cont, clear, trig, start, active, phase_ok;
  logic        rec_done, dly_done, miss;

  assign enable = ctrl_i[CTRL_EN];
  assign cont   = ctrl_i[CTRL_CONT];
  assign clear  = ctrl_i[CTRL_CLR];
  assign sel    = ctrl_i[CTRL_SEL_MSB:CTRL_SEL_LSB];
  assign trig   = trigger_vector_i[sel] & ~trig_prev[sel];

  // With zero delay the trigger cycle itself acts as the first RECORD cycle.
  assign start    = (state == ST_ARMED) && enable && trig;
  assign active   = enable && ((state == ST_RECORD) || (start && delay_i == 16'd0));
  assign len_eff  = (state == ST_RECORD) ? len_q : len_i;
  assign cnt_eff  = (state == ST_RECORD) ? pass_cnt : 16'd0;
  assign dly_done = (state == ST_DELAY) && enable && data_valid_i && (dly_cnt + 16'd1 == dly_q);
  assign miss     = trig && ((state == ST_DELAY) || (state == ST_RECORD) || (state == ST_DONE));

`ifdef USER_LOGIC_RECORD_DECIM_EN
  logic [3:0] phase, phase_eff;
  assign phase_eff = (state == ST_RECORD) ? phase : 4'd0;
  assign phase_ok  = (phase_eff == 4'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase <= 4'd0;
    end else if (!active) begin
      phase <= 4'd0;
    end else if (data_valid_i) begin
      phase <= (phase_eff == decim_i) ? 4'd0 : phase_eff + 4'd1;
    end else begin
      phase <= phase_eff;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim_i;
  assign phase_ok     = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_ARMED;
        ST_ARMED:  if (trig) state_next = (delay_i == 16'd0) ? ST_RECORD : ST_DELAY;
        ST_DELAY:  if (dly_done) state_next = ST_RECORD;
        ST_RECORD: if (rec_done) state_next = cont ? ST_ARMED : ST_DONE;
        ST_DONE:   state_next = ST_DONE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pass_o   = active && data_valid_i && phase_ok && (cnt_eff < len_eff);
    rec_done = (state == ST_RECORD) && enable &&
               ((cnt_eff == len_eff) || (pass_o && (cnt_eff + 16'd1 == len_eff)));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_prev  <= 4'd0;
      dly_q      <= 16'd0;
      len_q      <= 16'd0;
      dly_cnt    <= 16'd0;
      pass_cnt   <= 16'd0;
      rec_cnt_o  <= 16'd0;
      miss_cnt_o <= 16'd0;
    end else begin
      trig_prev <= trigger_vector_i;
      if (start) begin
        dly_q <= delay_i;
        len_q <= len_i;
      end
      if (state != ST_DELAY)  dly_cnt <= 16'd0;
      else if (data_valid_i)  dly_cnt <= dly_cnt + 16'd1;
      pass_cnt <= active ? cnt_eff + {15'd0, pass_o} : 16'd0;
      if (clear)         rec_cnt_o <= 16'd0;
      else if (rec_done) rec_cnt_o <= sat_inc(rec_cnt_o);
      if (clear)         miss_cnt_o <= 16'd0;
      else if (miss)     miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_i[15:6], ctrl_i[1]};
  assign state_o     = state;

endmodule

// File: rtl/user_logic_record_gate.sv
// Trigger-gated record packager top: output registers, channel muxing, status packing.
// Build with USER_LOGIC_RECORD_DECIM_EN to enable in-record decimation (reg3[3:0]).
module user_logic_record_gate
  import user_logic_record_pkg::*;
#(
  parameter int NofBits             = 16,
  parameter int NofChannels         = 2,
  parameter int NofUserRegistersOut = 4
) (
  input logic                     clk_i,
  input logic                     rst_n_i,
  user_logic_record_gate_if.slave bus
);

  localparam int W = NofBits * NofChannels;

  logic [REG_W-1:0] reg_ctrl, reg_delay, reg_len, reg_decim;
  logic [W-1:0]     y, yz;
  logic [3:0]       trig_q;
  logic             dv_q, pass;
  rec_state_e       state;
  logic [15:0]      rec_cnt, miss_cnt;
  logic [16*NofUserRegistersOut-1:0] status;

  assign reg_ctrl  = bus.user_register_i[REG_W*REG_CTRL  +: REG_W];
  assign reg_delay = bus.user_register_i[REG_W*REG_DELAY +: REG_W];
  assign reg_len   = bus.user_register_i[REG_W*REG_LEN   +: REG_W];
  assign reg_decim = bus.user_register_i[REG_W*REG_DECIM +: REG_W];

  user_logic_record_ctrl u_ctrl (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .data_valid_i     (bus.data_valid_i),
    .trigger_vector_i (bus.trigger_vector_i),
    .ctrl_i           (reg_ctrl),
    .delay_i          (reg_delay),
    .len_i            (reg_len),
    .decim_i          (reg_decim[3:0]),
    .pass_o           (pass),
    .state_o          (state),
    .rec_cnt_o        (rec_cnt),
    .miss_cnt_o       (miss_cnt)
  );

  // Gated samples load only when passed; otherwise the last record sample holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y      <= '0;
      yz     <= '0;
      dv_q   <= 1'b0;
      trig_q <= 4'd0;
    end else begin
      dv_q   <= pass;
      trig_q <= bus.trigger_vector_i;
      if (pass) begin
        for (int k = 0; k < NofChannels; k++) begin
          y[k*NofBits +: NofBits]  <= bus.x_i[k*NofBits +: NofBits];
          yz[k*NofBits +: NofBits] <= bus.xz_i[k*NofBits +: NofBits];
        end
      end
    end
  end

  always_comb begin
    status        = '0;
    status[2:0]   = state;
    status[31:16] = rec_cnt;
    status[47:32] = miss_cnt;
  end

  logic unused_regs;
  assign unused_regs = ^{bus.user_register_i[16*8-1:REG_W*4], reg_decim[15:4]};

  assign bus.y_o              = y;
  assign bus.yz_o             = yz;
  assign bus.data_valid_o     = dv_q;
  assign bus.trigger_vector_o = trig_q;
  assign bus.user_register_o  = status;

endmodule

// File: tb/tb_user_logic_record_gate.sv
// Directed bench for user_logic_record_gate; expectations follow USER_LOGIC_RECORD_DECIM_EN.
module tb_user_logic_record_gate;
  import user_logic_record_pkg::*;

  localparam int NB = 16;
  localparam int NC = 2;
  localparam int NU = 4;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b1;
  int          total   = 0;
  int          bad     = 0;
  logic [15:0] s       = 16'd0;
  logic [15:0] base;
  int          nvalid, first_k, last_k;
  logic [31:0] first_y, first_yz, hold_y, hold_y2;
  logic        gap_dv, dv_k1, dv_k2;
  logic [2:0]  st_k2;
  logic [31:0] ys[$];
  int          offs[3];

  user_logic_record_gate_if #(.NofBits(NB), .NofChannels(NC), .NofUserRegistersOut(NU)) bus ();

  user_logic_record_gate #(.NofBits(NB), .NofChannels(NC), .NofUserRegistersOut(NU)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] x_of(input logic [15:0] v);
    return {v + 16'h0100, v};
  endfunction

  function automatic logic [31:0] xz_of(input logic [15:0] v);
    return {v + 16'h0300, v + 16'h0200};
  endfunction

  task automatic set_reg(input int r, input logic [15:0] v);
    bus.user_register_i[16*r +: 16] = v;
  endtask

  // Drive one numbered sample with trigger/valid, then step to the next falling edge.
  task automatic applyStimulus(input logic [3:0] trig, input logic dv);
    bus.x_i              = x_of(s);
    bus.xz_i             = xz_of(s);
    bus.trigger_vector_i = trig;
    bus.data_valid_i     = dv;
    s = s + 16'd1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.x_i = '0; bus.xz_i = '0; bus.data_valid_i = 1'b0;
    bus.trigger_vector_i = 4'd0; bus.user_register_i = '0;
    #1 rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_dv", 32'(bus.data_valid_o), 32'd0);
    checkOutput("rst_y", bus.y_o, 32'd0);
    checkOutput("rst_regs", bus.user_register_o[31:0], 32'd0);
    rst_n_i = 1'b1;
    applyStimulus(4'hA, 1'b0);
    checkOutput("trig_delay", 32'(bus.trigger_vector_o), 32'hA);
    checkOutput("idle_state", 32'(bus.user_register_o[2:0]), 32'(ST_IDLE));

    $display("[TB] test 1: delay 3, length 5, one-shot");
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_DELAY, 16'd3); set_reg(REG_LEN, 16'd5);
    applyStimulus(4'h0, 1'b1);
    checkOutput("t1_armed", 32'(bus.user_register_o[2:0]), 32'(ST_ARMED));
    base = s; nvalid = 0; first_k = -1;
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (bus.data_valid_o) begin
        if (first_k < 0) begin first_k = k; first_y = bus.y_o; end
        nvalid++;
      end
    end
    checkOutput("t1_count", nvalid, 32'd5);
    checkOutput("t1_first_k", first_k, 32'd4);
    checkOutput("t1_first_y", first_y, x_of(base + 16'd4));
    checkOutput("t1_state", 32'(bus.user_register_o[2:0]), 32'(ST_DONE));
    checkOutput("t1_rec", 32'(bus.user_register_o[31:16]), 32'd1);
    checkOutput("t1_miss", 32'(bus.user_register_o[47:32]), 32'd0);

    set_reg(REG_CTRL, 16'h0000); applyStimulus(4'h0, 1'b1);
    checkOutput("dis_state", 32'(bus.user_register_o[2:0]), 32'(ST_IDLE));
    set_reg(REG_CTRL, 16'h0020); applyStimulus(4'h0, 1'b1);
    checkOutput("clr_rec", 32'(bus.user_register_o[31:16]), 32'd0);

    $display("[TB] test 2: zero delay, length 4, continuous, 3 triggers");
    set_reg(REG_CTRL, 16'h0015); set_reg(REG_DELAY, 16'd0); set_reg(REG_LEN, 16'd4);
    applyStimulus(4'h0, 1'b1);
    base = s; nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus((k % 10 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (k == 0) begin first_y = bus.y_o; first_yz = bus.yz_o; end
      if (bus.data_valid_o) nvalid++;
    end
    checkOutput("t2_first_y", first_y, x_of(base));
    checkOutput("t2_first_yz", first_yz, xz_of(base));
    checkOutput("t2_count", nvalid, 32'd12);
    checkOutput("t2_rec", 32'(bus.user_register_o[31:16]), 32'd3);
    checkOutput("t2_miss", 32'(bus.user_register_o[47:32]), 32'd0);
    checkOutput("t2_state", 32'(bus.user_register_o[2:0]), 32'(ST_ARMED));

    $display("[TB] test 3: trigger during record");
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_LEN, 16'd8);
    base = s; nvalid = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus((k == 0 || k == 3) ? 4'b0010 : 4'b0000, 1'b1);
      if (bus.data_valid_o) nvalid++;
    end
    checkOutput("t3_count", nvalid, 32'd8);
    checkOutput("t3_last_y", bus.y_o, x_of(base + 16'd7));
    checkOutput("t3_miss", 32'(bus.user_register_o[47:32]), 32'd1);
    checkOutput("t3_rec", 32'(bus.user_register_o[31:16]), 32'd4);

    $display("[TB] test 4: toggling data valid");
    set_reg(REG_CTRL, 16'h0000); applyStimulus(4'h0, 1'b1);
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_LEN, 16'd4); applyStimulus(4'h0, 1'b1);
    base = s; nvalid = 0; last_k = -1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, (k % 2 == 0));
      if (k == 1) begin hold_y = bus.y_o; gap_dv = bus.data_valid_o; end
      if (k == 7) hold_y2 = bus.y_o;
      if (bus.data_valid_o) begin nvalid++; last_k = k; end
    end
    checkOutput("t4_count", nvalid, 32'd4);
    checkOutput("t4_last_k", last_k, 32'd6);
    checkOutput("t4_gap_dv", 32'(gap_dv), 32'd0);
    checkOutput("t4_hold", hold_y, x_of(base));
    checkOutput("t4_hold_end", hold_y2, x_of(base + 16'd6));
    checkOutput("t4_rec", 32'(bus.user_register_o[31:16]), 32'd5);

    $display("[TB] test 5: enable drop and async reset mid-record");
    set_reg(REG_CTRL, 16'h0000); applyStimulus(4'h0, 1'b1);
    set_reg(REG_CTRL, 16'h0020); applyStimulus(4'h0, 1'b1);
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_LEN, 16'd8); applyStimulus(4'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) set_reg(REG_CTRL, 16'h0000);
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (k == 1) dv_k1 = bus.data_valid_o;
      if (k == 2) begin dv_k2 = bus.data_valid_o; st_k2 = bus.user_register_o[2:0]; end
    end
    checkOutput("t5_dv_before", 32'(dv_k1), 32'd1);
    checkOutput("t5_dv_abort", 32'(dv_k2), 32'd0);
    checkOutput("t5_state", 32'(st_k2), 32'(ST_IDLE));
    checkOutput("t5_rec", 32'(bus.user_register_o[31:16]), 32'd0);
    set_reg(REG_CTRL, 16'h0005); applyStimulus(4'h0, 1'b1);
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("t5_pre_dv", 32'(bus.data_valid_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("t5_rst_dv", 32'(bus.data_valid_o), 32'd0);
    checkOutput("t5_rst_y", bus.y_o, 32'd0);
    checkOutput("t5_rst_yz", bus.yz_o, 32'd0);
    checkOutput("t5_rst_trig", 32'(bus.trigger_vector_o), 32'd0);
    checkOutput("t5_rst_regs", bus.user_register_o[31:0], 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    $display("[TB] test 6: decimation");
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_DELAY, 16'd0);
    set_reg(REG_LEN, 16'd3); set_reg(REG_DECIM, 16'd2);
`ifdef USER_LOGIC_RECORD_DECIM_EN
    offs = '{0, 3, 6};
`else
    offs = '{0, 1, 2};
`endif
    applyStimulus(4'h0, 1'b1);
    base = s; ys.delete();
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (bus.data_valid_o) ys.push_back(bus.y_o);
    end
    checkOutput("t6_count", ys.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("t6_y%0d", i), (i < ys.size()) ? ys[i] : 32'hxxxxxxxx,
                  x_of(base + 16'(offs[i])));
    checkOutput("t6_state", 32'(bus.user_register_o[2:0]), 32'(ST_DONE));

    $display("[TB] test 7: zero-length record");
    set_reg(REG_CTRL, 16'h0000); applyStimulus(4'h0, 1'b1);
    set_reg(REG_CTRL, 16'h0005); set_reg(REG_LEN, 16'd0); applyStimulus(4'h0, 1'b1);
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 1'b1);
      if (bus.data_valid_o) nvalid++;
      if (k == 0) checkOutput("t7_in_record", 32'(bus.user_register_o[2:0]), 32'(ST_RECORD));
    end
    checkOutput("t7_count", nvalid, 32'd0);
    checkOutput("t7_rec", 32'(bus.user_register_o[31:16]), 32'd2);
    checkOutput("t7_state", 32'(bus.user_register_o[2:0]), 32'(ST_DONE));
    checkOutput("upper_regs", 32'(bus.user_register_o[63:48]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
